// File: rtl/led_pkg.sv
`default_nettype none
// led_pkg: shared mode and state encodings for the LED pattern generator.
// Revision 1.0
package led_pkg;

    localparam int BURST_W = 8;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_ON     = 2'd1,
        S_PH_ON  = 2'd2,
        S_PH_OFF = 2'd3
    } ch_state_t;

endpackage
`default_nettype wire

// File: rtl/led_pattern_gen_if.sv
`default_nettype none
// led_pattern_gen_if: configuration write channel between board control and the generator.
// Revision 1.0
interface led_pattern_gen_if #(
    parameter int CH_NUM = 4,
    parameter int TIME_W = 16
);
    import led_pkg::*;

    localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch;
    logic [1:0]          cfg_mode;
    logic [TIME_W-1:0]   cfg_on;
    logic [TIME_W-1:0]   cfg_off;
    logic [BURST_W-1:0]  cfg_burst;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_on, cfg_off, cfg_burst,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_on, cfg_off, cfg_burst,
        output cfg_ready
    );

endinterface
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// led_channel: one LED's OFF/ON/BLINK/BURST state machine with phase and burst counters.
// Revision 1.0
module led_channel
    import led_pkg::*;
#(
    parameter int TIME_W  = 16,
    parameter int DEF_ON  = 500,
    parameter int DEF_OFF = 500
) (
    input  wire logic               sys_clk,
    input  wire logic               sys_rst_n,
    input  wire logic               tick_i,
    input  wire logic               wr_i,
    input  wire logic [1:0]         mode_i,
    input  wire logic [TIME_W-1:0]  on_i,
    input  wire logic [TIME_W-1:0]  off_i,
    input  wire logic [BURST_W-1:0] burst_i,
    output logic                    led_o,
    output logic                    busy_o
);

    localparam logic [TIME_W-1:0] ONE = TIME_W'(1);

    ch_state_t          state_q, state_d;
    logic [TIME_W-1:0]  on_len_q, on_len_d;
    logic [TIME_W-1:0]  off_len_q, off_len_d;
    logic [TIME_W-1:0]  cnt_q, cnt_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               burst_q, burst_d;
    logic [TIME_W-1:0]  w_len;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_PH_ON;
            on_len_q  <= TIME_W'(DEF_ON);
            off_len_q <= TIME_W'(DEF_OFF);
            cnt_q     <= '0;
            rem_q     <= '0;
            burst_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            on_len_q  <= on_len_d;
            off_len_q <= off_len_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            burst_q   <= burst_d;
        end
    end

    assign w_len = (state_q == S_PH_OFF) ? off_len_q : on_len_q;

    always_comb begin
        state_d   = state_q;
        on_len_d  = on_len_q;
        off_len_d = off_len_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        burst_d   = burst_q;
        // A write to this channel overrides any phase end landing on the same edge.
        if (wr_i) begin
            on_len_d  = (on_i  == '0) ? ONE : on_i;
            off_len_d = (off_i == '0) ? ONE : off_i;
            cnt_d     = '0;
            burst_d   = 1'b0;
            rem_d     = '0;
            case (mode_i)
                MODE_OFF:   state_d = S_OFF;
                MODE_ON:    state_d = S_ON;
                MODE_BLINK: state_d = S_PH_ON;
                default: begin
                    burst_d = 1'b1;
                    rem_d   = burst_i;
                    state_d = (burst_i == '0) ? S_OFF : S_PH_ON;
                end
            endcase
        end else if (tick_i && (state_q == S_PH_ON || state_q == S_PH_OFF)) begin
            if (cnt_q == w_len - ONE) begin
                cnt_d = '0;
                if (state_q == S_PH_ON) begin
                    state_d = S_PH_OFF;
                end else if (burst_q) begin
                    rem_d   = rem_q - BURST_W'(1);
                    state_d = (rem_q == BURST_W'(1)) ? S_OFF : S_PH_ON;
                end else begin
                    state_d = S_PH_ON;
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    assign led_o  = (state_q == S_ON) || (state_q == S_PH_ON);
    assign busy_o = burst_q && (rem_q != '0);

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// led_pattern_gen: shared tick prescaler, config decode and CH_NUM pattern channels.
// Revision 1.0
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int CH_NUM      = 4,
    parameter int TIME_W      = 16,
    parameter int DEF_ON      = 500,
    parameter int DEF_OFF     = 500
) (
    input  wire logic        sys_clk,
    input  wire logic        sys_rst_n,
    led_pattern_gen_if.slave cfg,
    output logic [CH_NUM-1:0] led_out,
    output logic [CH_NUM-1:0] busy
);

    localparam int P     = CLK_FREQ_HZ / TICK_HZ;
    localparam int PRE_W = (P > 1) ? $clog2(P) : 1;
    localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    logic [PRE_W-1:0] pre_q;
    logic             ready_q;
    logic             w_tick;
    logic             w_accept;

    assign w_tick   = (pre_q == PRE_W'(P - 1));
    assign w_accept = cfg.cfg_valid & ready_q;

    // The prescaler free-runs; configuration writes never realign it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            pre_q   <= w_tick ? '0 : pre_q + PRE_W'(1);
            ready_q <= 1'b1;
        end
    end

    assign cfg.cfg_ready = ready_q;

    // Channel indices beyond CH_NUM-1 match no instance, so such writes drop silently.
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        led_channel #(
            .TIME_W  (TIME_W),
            .DEF_ON  (DEF_ON),
            .DEF_OFF (DEF_OFF)
        ) u_ch (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .tick_i    (w_tick),
            .wr_i      (w_accept && (cfg.cfg_ch == CH_W'(i))),
            .mode_i    (cfg.cfg_mode),
            .on_i      (cfg.cfg_on),
            .off_i     (cfg.cfg_off),
            .burst_i   (cfg.cfg_burst),
            .led_o     (led_out[i]),
            .busy_o    (busy[i])
        );
    end

endmodule
`default_nettype wire

// File: doc/led_pattern_gen.md
# led_pattern_gen

Multi-channel LED pattern generator: the parametrised successor to the single-LED fixed 0.5 s blink counter. A shared prescaler derives a millisecond-class tick from sys_clk. Each of CH_NUM channels runs its own OFF / ON / BLINK / BURST pattern with runtime-programmable on and off times in ticks. It sits between the board-control logic (configuration writes) and the LED pins.

## Interface
- CLK_FREQ_HZ, 50_000_000: sys_clk frequency.
- TICK_HZ, 1000: tick rate. CLK_FREQ_HZ/TICK_HZ must be an integer ≥ 2.
- CH_NUM, 4: channel count, 1..16.
- TIME_W, 16: width of on/off time fields, in ticks.
- DEF_ON, 500: reset on-time, in ticks.
- DEF_OFF, 500: reset off-time, in ticks.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  reset: asynchronous, active-low.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  write accepted when cfg_valid & cfg_ready.
- cfg_ch  in  max(1,$clog2(CH_NUM))  target channel.
- cfg_mode  in  2  0 OFF, 1 ON, 2 BLINK, 3 BURST.
- cfg_on  in  TIME_W  on-phase length, in ticks.
- cfg_off  in  TIME_W  off-phase length, in ticks.
- cfg_burst  in  8  number of on/off cycles for BURST.
- led_out  out  CH_NUM  LED drive, 1 = lit.
- busy  out  CH_NUM  channel is in BURST with cycles remaining.

## Operation
- **Prescaler:** free-running counter 0..CLK_FREQ_HZ/TICK_HZ−1. It emits a one-cycle internal tick when it wraps. It is never reset by configuration writes.
- **Per-channel FSM states:** S_OFF (led 0), S_ON (led 1), S_PH_ON (led 1), S_PH_OFF (led 0).
- **Per-channel registers:** on_len, off_len, phase counter cnt (TIME_W), remaining-burst counter rem (8 bits), and a burst flag.
- **Zero clamp:** cfg_on = 0 or cfg_off = 0 is stored as 1.
- **Write accept:** cfg_ready is 0 while in reset and 1 from the first edge after reset release; it never deasserts otherwise. On an accepted write, the channel loads its lengths, sets cnt = 0, and enters:
  - OFF → S_OFF.
  - ON → S_ON.
  - BLINK → S_PH_ON.
  - BURST with cfg_burst > 0 → S_PH_ON, rem = cfg_burst.
  - BURST with cfg_burst = 0 → S_OFF.
- **Phase counting:** in S_PH_ON and S_PH_OFF, each tick increments cnt.
  - When tick && cnt == len−1: cnt ← 0 and the phase toggles.
- **Burst countdown:** at the end of S_PH_OFF in burst, rem decrements. If rem reaches 0, the channel goes to S_OFF instead of S_PH_ON.
- **busy** = burst flag && rem ≠ 0.
- **Out-of-range cfg_ch:** possible when CH_NUM is not a power of 2. The write is accepted (handshake completes) and ignored.
- **Simultaneous events:** a write to a channel on the same cycle as that channel's phase end takes priority; the phase transition is discarded. Writes to other channels do not disturb this channel.

## Timing
- **Reset values:** every channel in S_PH_ON (BLINK, DEF_ON/DEF_OFF), cnt = 0, rem = 0, prescaler = 0. led_out = all 1s, busy = 0, cfg_ready = 0.
- **Write latency:** led_out and busy reflect an accepted write at the same clock edge that accepts it (registered outputs, one cycle after cfg_valid is sampled).
- **Phase length:** a phase of L ticks lasts L×P cycles, where P = CLK_FREQ_HZ/TICK_HZ. The first phase after a write is L×P − k cycles, where k ∈ [0, P−1] is the prescaler offset.
- **Reset mid-operation:** asynchronously returns everything to the reset values, including any burst in progress.
- **Widths:** cnt compare is done at TIME_W bits, with no wrap beyond len−1.

## Structure
- **Package led_pkg:**
  - mode encoding constants (MODE_OFF/ON/BLINK/BURST);
  - channel state encoding;
  - BURST_W = 8.
- **Sub-module led_channel:** the per-channel FSM and counters. It is instantiated CH_NUM times in a generate loop. The prescaler and cfg decode stay in the top level.

## Test plan
Test setup: CLK_FREQ_HZ=100, TICK_HZ=10 (P=10), CH_NUM=3, DEF_ON=3, DEF_OFF=2.

1. **Reset default:** release reset → all led_out=1 for 30 cycles, then 0 for 20 cycles, repeating. busy=0 and cfg_ready=1 one cycle after release.
2. **Mode writes:** write ch1 OFF, then ch2 ON → led_out[1]=0 and led_out[2]=1 at the accepting edge, held for 500 cycles. ch0 keeps blinking undisturbed.
3. **Burst:** write ch0 BURST, on=1, off=1, burst=3 → led_out[0] gives 3 pulses, each ≤10 cycles high, then stays 0. busy[0] falls at the edge where the last off phase ends.
4. **Burst boundaries:** burst=0 → immediate led 0 and busy 0. cfg_on=0 → behaves as on=1.
5. **Collision:** write ch0 BLINK on the exact cycle its phase ends → the write wins: led 1, cnt restarts. Also write cfg_ch=3 → ignored, no channel changes.
6. **Reset mid-burst:** pulse sys_rst_n low mid-burst → asynchronous return to reset values; busy=0 immediately.
